// File: rtl/draw_wr_queue_pkg.sv
// Shared types and constants for the draw-engine write queue.
//   draw_wr_t      : one queued pixel write {mask, addr, data}.
//   DRAW_WRQ_DEPTH : default FIFO depth.
package draw_wr_queue_pkg;

  localparam int DRAW_WRQ_DEPTH = 8;

  typedef struct packed {
    logic [3:0]  mask;
    logic [15:0] addr;
    logic [15:0] data;
  } draw_wr_t;

endpackage

// File: rtl/draw_wr_queue.sv
// draw_wr_queue: show-ahead write buffer between the draw engine and the
// VRAM arbiter. It absorbs one write per cycle from the draw engine and
// replays the writes to VRAM under a req/ack handshake. It throttles the
// engine through draw_oe_o.
//
// Handshake: vram_req_o is high whenever the queue holds an entry. The
// vram_* fields show the head entry and stay stable until the arbiter
// answers with vram_ack_i. The head is consumed on the edge where both
// req and ack are high.
//
// Optional feature: define DRAW_WR_COALESCE_EN to merge a push into the
// newest entry when the addresses match. A merge never targets a head
// that is being popped in the same cycle.
//
// Ports:
//   clk, reset_i                   clock, synchronous active-high reset
//   draw_vram_sel_i, draw_wr_i     draw engine write qualifiers
//   draw_mask_i/addr_i/data_i      draw engine write payload
//   draw_oe_o                      engine output enable (count < DEPTH-1)
//   vram_req_o, vram_ack_i         request/grant to the VRAM arbiter
//   vram_wr_o                      equals vram_req_o
//   vram_mask_o/addr_o/data_o      head entry payload
//   busy_o                         queue non-empty
//   overflow_o                     sticky: push dropped on a full queue
module draw_wr_queue
  import draw_wr_queue_pkg::*;
#(
  parameter int DEPTH = DRAW_WRQ_DEPTH
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        draw_vram_sel_i,
  input  logic        draw_wr_i,
  input  logic [3:0]  draw_mask_i,
  input  logic [15:0] draw_addr_i,
  input  logic [15:0] draw_data_i,
  output logic        draw_oe_o,
  output logic        vram_req_o,
  input  logic        vram_ack_i,
  output logic        vram_wr_o,
  output logic [3:0]  vram_mask_o,
  output logic [15:0] vram_addr_o,
  output logic [15:0] vram_data_o,
  output logic        busy_o,
  output logic        overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  draw_wr_t           r_mem [DEPTH];
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_oe_q;
  logic               r_overflow;

  draw_wr_t           w_in;
  draw_wr_t           w_head;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_alloc;
  logic               w_alloc_ok;
  logic               w_drop;

`ifdef DRAW_WR_COALESCE_EN
  logic [PTR_W-1:0]   w_newest_ptr;
  logic               w_merge;

  // Overlay the incoming nibbles selected by its mask onto an older entry.
  function automatic draw_wr_t merge_wr(input draw_wr_t old_wr, input draw_wr_t new_wr);
    draw_wr_t res;
    res      = old_wr;
    res.mask = old_wr.mask | new_wr.mask;
    for (int i = 0; i < 4; i++) begin
      if (new_wr.mask[i]) res.data[i*4 +: 4] = new_wr.data[i*4 +: 4];
    end
    return res;
  endfunction

  assign w_newest_ptr = r_wr_ptr - PTR_W'(1);
  // With one entry the newest is the head; if it leaves this cycle, allocate.
  assign w_merge = w_push && (r_count != '0) &&
                   (r_mem[w_newest_ptr].addr == draw_addr_i) &&
                   !(w_pop && (r_count == CNT_W'(1)));
  assign w_alloc = w_push && !w_merge;
`else
  assign w_alloc = w_push;
`endif

  assign w_in       = '{mask: draw_mask_i, addr: draw_addr_i, data: draw_data_i};
  assign w_head     = r_mem[r_rd_ptr];

  // oe_q masks the engine's held output registers so they are not recaptured.
  assign w_push     = draw_vram_sel_i && draw_wr_i && r_oe_q;
  assign w_pop      = vram_req_o && vram_ack_i;
  assign w_full     = (r_count == CNT_W'(DEPTH));
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign w_alloc_ok = w_alloc && (!w_full || w_pop);
  assign w_drop     = w_alloc && w_full && !w_pop;

  assign draw_oe_o   = (r_count < CNT_W'(DEPTH - 1));
  assign vram_req_o  = (r_count != '0);
  assign vram_wr_o   = vram_req_o;
  assign busy_o      = vram_req_o;
  assign vram_mask_o = w_head.mask;
  assign vram_addr_o = w_head.addr;
  assign vram_data_o = w_head.data;
  assign overflow_o  = r_overflow;

  // Storage needs no reset; the count alone defines validity.
  always_ff @(posedge clk) begin
    if (!reset_i) begin
      if (w_alloc_ok) begin
        r_mem[r_wr_ptr] <= w_in;
      end
`ifdef DRAW_WR_COALESCE_EN
      else if (w_merge) begin
        r_mem[w_newest_ptr] <= merge_wr(r_mem[w_newest_ptr], w_in);
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_oe_q     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_oe_q <= draw_oe_o;
      if (w_alloc_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)      r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_alloc_ok, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_draw_wr_queue.sv
module tb_draw_wr_queue;

  logic        clk;
  logic        reset_i;
  logic        draw_vram_sel_i;
  logic        draw_wr_i;
  logic [3:0]  draw_mask_i;
  logic [15:0] draw_addr_i;
  logic [15:0] draw_data_i;
  logic        draw_oe_o;
  logic        vram_req_o;
  logic        vram_ack_i;
  logic        vram_wr_o;
  logic [3:0]  vram_mask_o;
  logic [15:0] vram_addr_o;
  logic [15:0] vram_data_o;
  logic        busy_o;
  logic        overflow_o;

  int n_assert = 0;
  int n_fail   = 0;

  logic [3:0]  v_mask [8];
  logic [15:0] v_addr [8];
  logic [15:0] v_data [8];

  draw_wr_queue #(.DEPTH(8)) dut (
    .clk             (clk),
    .reset_i         (reset_i),
    .draw_vram_sel_i (draw_vram_sel_i),
    .draw_wr_i       (draw_wr_i),
    .draw_mask_i     (draw_mask_i),
    .draw_addr_i     (draw_addr_i),
    .draw_data_i     (draw_data_i),
    .draw_oe_o       (draw_oe_o),
    .vram_req_o      (vram_req_o),
    .vram_ack_i      (vram_ack_i),
    .vram_wr_o       (vram_wr_o),
    .vram_mask_o     (vram_mask_o),
    .vram_addr_o     (vram_addr_o),
    .vram_data_o     (vram_data_o),
    .busy_o          (busy_o),
    .overflow_o      (overflow_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one cycle; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [3:0] m, input logic [15:0] a,
                            input logic [15:0] d);
    check({tag, "_req"}, {35'd0, vram_req_o}, 36'd1);
    check({tag, "_wr"}, {35'd0, vram_wr_o}, 36'd1);
    check({tag, "_fields"}, {vram_mask_o, vram_addr_o, vram_data_o}, {m, a, d});
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_req"}, {35'd0, vram_req_o}, 36'd0);
    check({tag, "_busy"}, {35'd0, busy_o}, 36'd0);
    check({tag, "_oe"}, {35'd0, draw_oe_o}, 36'd1);
  endtask

  // driver
  task automatic drive(input logic wr, input logic [3:0] m, input logic [15:0] a,
                       input logic [15:0] d);
    draw_vram_sel_i = 1'b1;
    draw_wr_i       = wr;
    draw_mask_i     = m;
    draw_addr_i     = a;
    draw_data_i     = d;
  endtask

  initial begin
    int  k;
    logic oe_before;

    v_mask[0] = 4'h1; v_addr[0] = 16'h0100; v_data[0] = 16'hD000;
    v_mask[1] = 4'h2; v_addr[1] = 16'h0101; v_data[1] = 16'hD111;
    v_mask[2] = 4'h3; v_addr[2] = 16'h0102; v_data[2] = 16'hD222;
    v_mask[3] = 4'h4; v_addr[3] = 16'h0103; v_data[3] = 16'hD333;
    v_mask[4] = 4'h5; v_addr[4] = 16'h0104; v_data[4] = 16'hD444;
    v_mask[5] = 4'h6; v_addr[5] = 16'h0105; v_data[5] = 16'hD555;
    v_mask[6] = 4'h7; v_addr[6] = 16'h0106; v_data[6] = 16'hD666;
    v_mask[7] = 4'h8; v_addr[7] = 16'h0107; v_data[7] = 16'hD777;

    reset_i    = 1'b1;
    vram_ack_i = 1'b0;
    drive(1'b0, 4'h0, 16'h0000, 16'h0000);
    draw_vram_sel_i = 1'b0;
    tick(); tick(); tick();
    reset_i = 1'b0;
    tick(); tick();

    // reset state, idle
    check_idle("reset");
    check("reset_ovf", {35'd0, overflow_o}, 36'd0);

    // single push with ack tied high
    vram_ack_i = 1'b1;
    drive(1'b1, 4'b1100, 16'h1234, 16'hA5A5);
    tick();
    drive(1'b0, 4'h0, 16'h0000, 16'h0000);
    check_head("single", 4'b1100, 16'h1234, 16'hA5A5);
    tick();
    check_idle("single_done");

    // throttle: ack low, engine loads a new vector only while draw_oe_o was high
    vram_ack_i = 1'b0;
    k = 0;
    drive(1'b1, v_mask[0], v_addr[0], v_data[0]);
    for (int t = 1; t <= 10; t++) begin
      oe_before = draw_oe_o;
      tick();
      if (oe_before && k < 7) begin
        k++;
        drive(1'b1, v_mask[k], v_addr[k], v_data[k]);
      end
      check($sformatf("thr_oe_t%0d", t), {35'd0, draw_oe_o}, {35'd0, (t <= 6)});
    end
    check("thr_k", 36'(k), 36'd7);
    check("thr_busy", {35'd0, busy_o}, 36'd1);
    check("thr_ovf", {35'd0, overflow_o}, 36'd0);
    drive(1'b0, 4'h0, 16'h0000, 16'h0000);
    vram_ack_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_head($sformatf("drain%0d", i), v_mask[i], v_addr[i], v_data[i]);
      tick();
    end
    check_idle("drain_done");
    check("drain_ovf", {35'd0, overflow_o}, 36'd0);

    // same-address pair with ack low
    vram_ack_i = 1'b0;
    drive(1'b1, 4'b1100, 16'h0010, 16'h4400);
    tick();
    drive(1'b1, 4'b0011, 16'h0010, 16'h0033);
    tick();
    drive(1'b0, 4'h0, 16'h0000, 16'h0000);
`ifdef DRAW_WR_COALESCE_EN
    check_head("coal_merged", 4'b1111, 16'h0010, 16'h4433);
    vram_ack_i = 1'b1;
    tick();
    check_idle("coal_done");
`else
    check_head("coal_first", 4'b1100, 16'h0010, 16'h4400);
    vram_ack_i = 1'b1;
    tick();
    check_head("coal_second", 4'b0011, 16'h0010, 16'h0033);
    tick();
    check_idle("coal_done");
`endif

    // same address as the sole entry while it is popped: must allocate
    vram_ack_i = 1'b0;
    drive(1'b1, 4'b1111, 16'h0020, 16'h1111);
    tick();
    drive(1'b1, 4'b0001, 16'h0020, 16'h0002);
    vram_ack_i = 1'b1;
    check_head("popm_first", 4'b1111, 16'h0020, 16'h1111);
    tick();
    drive(1'b0, 4'h0, 16'h0000, 16'h0000);
    check_head("popm_second", 4'b0001, 16'h0020, 16'h0002);
    tick();
    check_idle("popm_done");

    // reset with 5 entries pending
    vram_ack_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'hF, 16'h0300 + 16'(i), 16'h3000 + 16'(i));
      tick();
    end
    drive(1'b0, 4'h0, 16'h0000, 16'h0000);
    check_head("rst_pending", 4'hF, 16'h0300, 16'h3000);
    check("rst_pending_oe", {35'd0, draw_oe_o}, 36'd1);
    reset_i = 1'b1;
    tick();
    check_idle("rst_flush");
    reset_i = 1'b0;
    tick();
    drive(1'b1, 4'hA, 16'h0400, 16'hBEEF);
    tick();
    drive(1'b0, 4'h0, 16'h0000, 16'h0000);
    vram_ack_i = 1'b1;
    check_head("rst_after", 4'hA, 16'h0400, 16'hBEEF);
    tick();
    check_idle("rst_after_done");
    check("final_ovf", {35'd0, overflow_o}, 36'd0);

    // report
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
